// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder
// Target side of a 68k asynchronous bus cycle. Strobes are synchronized to C,
// a matching cycle is acknowledged with DSACK_n after WAIT_STATES extra cycles,
// and a small register bank (three R/W words plus a read-only ID word) backs it.
// Writes to the ID word terminate with BERR_n instead of DSACK_n.
module m68k_bus_responder #(
   parameter int          WAIT_STATES = 2,
   parameter logic [3:0]  BASE        = 4'hA,
   parameter logic [31:0] ID_VALUE    = 32'h0060DCA1
) (
   input  logic        C,
   input  logic        CLR,
   input  logic        AS_n,
   input  logic        DS_n,
   input  logic        RW,
   input  logic [7:0]  A,
   input  logic [31:0] D_IN,
   output logic [31:0] D_OUT,
   output logic        D_OE,
   output logic [1:0]  DSACK_n,
   output logic        BERR_n
);

   localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   state_t      state, state_nxt;

   // two-flop synchronizer stages, reset to the inactive (high) level
   logic        as_sync_p0, as_sync_p1;
   logic        ds_sync_p0, ds_sync_p1;
   logic        as_s, ds_s;

   // a new cycle may start only after the strobe was seen released
   logic        armed;

   logic [3:0]  cnt, cnt_nxt;
   logic        latch;
   logic [1:0]  idx_q;
   logic        rw_q;
   logic [31:0] wd_q;

   logic [31:0] regs [0:2];

   logic        sel;
   logic [1:0]  cur_idx;
   logic        cur_rw;
   logic [31:0] cur_wd;
   logic [31:0] rd_data;
   logic        ack_entry;
   logic        wr_en;

   assign as_s = ~as_sync_p1;
   assign ds_s = ~ds_sync_p1;
   assign sel  = as_s && ds_s && armed && (A[7:4] == BASE);

   // In IDLE the cycle attributes come straight from the bus so that a
   // zero-wait-state cycle can complete on the same edge it is recognized.
   assign cur_idx = (state == S_IDLE) ? A[3:2] : idx_q;
   assign cur_rw  = (state == S_IDLE) ? RW     : rw_q;
   assign cur_wd  = (state == S_IDLE) ? D_IN   : wd_q;

   // Synchronize the asynchronous strobes into the C domain
   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         as_sync_p0 <= 1'b1;
         as_sync_p1 <= 1'b1;
         ds_sync_p0 <= 1'b1;
         ds_sync_p1 <= 1'b1;
      end else begin
         as_sync_p0 <= AS_n;
         as_sync_p1 <= as_sync_p0;
         ds_sync_p0 <= DS_n;
         ds_sync_p1 <= ds_sync_p0;
      end
   end

   // Read mux over the register bank, ID word is a constant
   always_comb begin
      rd_data = ID_VALUE;
      case (cur_idx)
         2'd0:    rd_data = regs[0];
         2'd1:    rd_data = regs[1];
         2'd2:    rd_data = regs[2];
         default: rd_data = ID_VALUE;
      endcase
   end

   // Next-state logic: recognize, wait, then terminate with ACK or ERR
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      latch     = 1'b0;
      case (state)
         S_IDLE: begin
            if (sel) begin
               latch = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_nxt = (!RW && (A[3:2] == 2'd3)) ? S_ERR : S_ACK;
               end else begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = WS_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (!as_s) begin
               state_nxt = S_IDLE;
            end else if (cnt == 4'd1) begin
               state_nxt = (!rw_q && (idx_q == 2'd3)) ? S_ERR : S_ACK;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         S_ACK: begin
            if (!as_s) state_nxt = S_IDLE;
         end
         S_ERR: begin
            if (!as_s) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign ack_entry = (state != S_ACK) && (state_nxt == S_ACK);
   assign wr_en     = ack_entry && !cur_rw;

   // State register, wait counter and strobe re-arm tracking
   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
         armed <= 1'b1;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (!as_s) begin
            armed <= 1'b1;
         end else if (latch) begin
            armed <= 1'b0;
         end
      end
   end

   // Capture the cycle attributes when the cycle is recognized
   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         idx_q <= 2'd0;
         rw_q  <= 1'b1;
         wd_q  <= 32'd0;
      end else if (latch) begin
         idx_q <= A[3:2];
         rw_q  <= RW;
         wd_q  <= D_IN;
      end
   end

   // Register bank write, committed on the edge that enters ACK
   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         for (int i = 0; i < 3; i++) regs[i] <= 32'd0;
      end else if (wr_en) begin
         case (cur_idx)
            2'd0:    regs[0] <= cur_wd;
            2'd1:    regs[1] <= cur_wd;
            2'd2:    regs[2] <= cur_wd;
            default: ;
         endcase
      end
   end

   // Registered bus outputs, driven from the next state
   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         DSACK_n <= 2'b11;
         BERR_n  <= 1'b1;
         D_OE    <= 1'b0;
         D_OUT   <= 32'd0;
      end else begin
         DSACK_n <= (state_nxt == S_ACK) ? 2'b00 : 2'b11;
         BERR_n  <= (state_nxt != S_ERR);
         D_OE    <= (state_nxt == S_ACK) && cur_rw;
         if (ack_entry && cur_rw) begin
            D_OUT <= rd_data;
         end else if (state_nxt != S_ACK) begin
            D_OUT <= 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Bench for m68k_bus_responder: bus cycles are driven one at a time, the
// expected termination for each is queued when it is driven and popped and
// compared when the responder answers (or the cycle budget runs out).
module tb_m68k_bus_responder;

   localparam int WS = 2;

   logic        C = 1'b0;
   logic        CLR;
   logic        AS_n, DS_n, RW;
   logic [7:0]  A;
   logic [31:0] D_IN;
   logic [31:0] D_OUT;
   logic        D_OE;
   logic [1:0]  DSACK_n;
   logic        BERR_n;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string       tag;
      int          edge_no;
      logic [1:0]  dsack;
      logic        berr;
      logic        oe;
      logic [31:0] d;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mreg [4];

   m68k_bus_responder #(
      .WAIT_STATES(WS),
      .BASE(4'hA),
      .ID_VALUE(32'h0060DCA1)
   ) dut (
      .C(C),
      .CLR(CLR),
      .AS_n(AS_n),
      .DS_n(DS_n),
      .RW(RW),
      .A(A),
      .D_IN(D_IN),
      .D_OUT(D_OUT),
      .D_OE(D_OE),
      .DSACK_n(DSACK_n),
      .BERR_n(BERR_n)
   );

   always #5 C = ~C;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mreg[0] = 32'd0;
      mreg[1] = 32'd0;
      mreg[2] = 32'd0;
      mreg[3] = 32'h0060DCA1;
   endtask

   // One bus cycle. abort_edge>0 raises the strobes after that edge;
   // clr_on_ack pulses CLR while the cycle is being acknowledged.
   task automatic do_cycle(input string tag, input logic [7:0] addr, input logic rw,
                           input logic [31:0] wd, input int abort_edge, input bit clr_on_ack);
      exp_t       e;
      logic [1:0] idx;
      bit         resp;
      int         k;
      idx       = addr[3:2];
      e.tag     = tag;
      e.edge_no = 0;
      e.dsack   = 2'b11;
      e.berr    = 1'b1;
      e.oe      = 1'b0;
      e.d       = 32'd0;
      if (addr[7:4] == 4'hA && abort_edge == 0) begin
         e.edge_no = 3 + WS;
         if (!rw && idx == 2'd3) begin
            e.berr = 1'b0;
         end else begin
            e.dsack = 2'b00;
            if (rw) begin
               e.oe = 1'b1;
               e.d  = mreg[idx];
            end else begin
               mreg[idx] = wd;
            end
         end
      end
      sb.push_back(e);

      A = addr; RW = rw; D_IN = wd; AS_n = 1'b0; DS_n = 1'b0;
      resp = 1'b0;
      k = 0;
      while (!resp && k < 20) begin
         @(posedge C); #1;
         k++;
         if (DSACK_n != 2'b11 || !BERR_n || D_OE) resp = 1'b1;
         if (k == abort_edge) begin
            AS_n = 1'b1; DS_n = 1'b1;
         end
      end

      e = sb.pop_front();
      chk({e.tag, "_edge"}, resp ? k : 0, e.edge_no);
      if (resp) begin
         chk({e.tag, "_dsack"}, {30'd0, DSACK_n}, {30'd0, e.dsack});
         chk({e.tag, "_berr"}, {31'd0, BERR_n}, {31'd0, e.berr});
         chk({e.tag, "_oe"}, {31'd0, D_OE}, {31'd0, e.oe});
         if (e.oe) chk({e.tag, "_data"}, D_OUT, e.d);
         if (clr_on_ack) begin
            #1 CLR = 1'b1;
            #1;
            chk({e.tag, "_clr_rel"}, {28'd0, DSACK_n, BERR_n, D_OE}, 32'b1110);
            model_reset();
            AS_n = 1'b1; DS_n = 1'b1;
            @(posedge C); #1;
            chk({e.tag, "_clr_hold"}, {28'd0, DSACK_n, BERR_n, D_OE}, 32'b1110);
            CLR = 1'b0;
         end else begin
            AS_n = 1'b1; DS_n = 1'b1;
            @(posedge C); #1;
            @(posedge C); #1;
            chk({e.tag, "_hold"}, {29'd0, DSACK_n, BERR_n}, {29'd0, e.dsack, e.berr});
            @(posedge C); #1;
            chk({e.tag, "_rel"}, {28'd0, DSACK_n, BERR_n, D_OE}, 32'b1110);
         end
      end else begin
         AS_n = 1'b1; DS_n = 1'b1;
      end
      repeat (3) @(posedge C);
      #1;
   endtask

   initial begin
      model_reset();
      CLR = 1'b1; AS_n = 1'b0; DS_n = 1'b0; RW = 1'b1; A = 8'hAC; D_IN = 32'd0;
      repeat (3) @(posedge C);
      #1;
      chk("rst_dsack", {30'd0, DSACK_n}, 32'b11);
      chk("rst_berr", {31'd0, BERR_n}, 32'd1);
      chk("rst_oe", {31'd0, D_OE}, 32'd0);
      chk("rst_dout", D_OUT, 32'd0);
      AS_n = 1'b1; DS_n = 1'b1;
      repeat (2) @(posedge C);
      #1 CLR = 1'b0;
      repeat (3) @(posedge C);
      #1;

      do_cycle("rd_id", 8'hAC, 1'b1, 32'd0, 0, 1'b0);
      do_cycle("abort_wr1", 8'hA4, 1'b0, 32'h12345678, 2, 1'b0);
      do_cycle("rd1_after_abort", 8'hA4, 1'b1, 32'd0, 0, 1'b0);
      do_cycle("wr1", 8'hA4, 1'b0, 32'hDEADBEEF, 0, 1'b0);
      do_cycle("rd1", 8'hA4, 1'b1, 32'd0, 0, 1'b0);
      do_cycle("wr2", 8'hA8, 1'b0, 32'hCAFEF00D, 0, 1'b0);
      do_cycle("rd0", 8'hA0, 1'b1, 32'd0, 0, 1'b0);
      do_cycle("rd2", 8'hA8, 1'b1, 32'd0, 0, 1'b0);
      do_cycle("miss_wr", 8'h54, 1'b0, 32'h55AA55AA, 0, 1'b0);
      do_cycle("miss_rd", 8'h54, 1'b1, 32'd0, 0, 1'b0);
      do_cycle("ro_err", 8'hAC, 1'b0, 32'hFFFFFFFF, 0, 1'b0);
      do_cycle("rd_id_after_err", 8'hAC, 1'b1, 32'd0, 0, 1'b0);
      do_cycle("rd1_again", 8'hA4, 1'b1, 32'd0, 0, 1'b0);
      do_cycle("clr_mid_ack", 8'hA4, 1'b1, 32'd0, 0, 1'b1);
      do_cycle("rd1_after_clr", 8'hA4, 1'b1, 32'd0, 0, 1'b0);
      do_cycle("wr0_after_clr", 8'hA0, 1'b0, 32'h0BADF00D, 0, 1'b0);
      do_cycle("rd0_after_clr", 8'hA0, 1'b1, 32'd0, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
